// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative restoring divider.
//   div_state_t : controller states (IDLE, RUN, FIN)
//   div_cnt_w() : iteration counter width for a given DATAWIDTH, $clog2(DATAWIDTH)
// -----------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

   // The counter counts down from DATAWIDTH-1 to 0, so $clog2(DATAWIDTH) bits suffice.
   function automatic int div_cnt_w(input int dw);
      return (dw < 2) ? 1 : $clog2(dw);
   endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   prem    in  [DATAWIDTH:0]   partial remainder before the step
//   in_bit  in  1               next dividend bit shifted into the remainder
//   divisor in  [DATAWIDTH-1:0] divisor
//   nrem    out [DATAWIDTH:0]   partial remainder after the step
//   qbit    out 1               quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step
   import div_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic [DATAWIDTH:0]   prem,
   input  logic                 in_bit,
   input  logic [DATAWIDTH-1:0] divisor,
   output logic [DATAWIDTH:0]   nrem,
   output logic                 qbit
);

   logic [DATAWIDTH+1:0] shifted;
   logic [DATAWIDTH+1:0] diff;

   // One guard bit above the shifted remainder carries the sign of the trial
   // subtraction; a clear sign bit means the divisor fit.
   always_comb begin
      shifted = {prem, in_bit};
      diff    = shifted - {2'b00, divisor};
      qbit    = ~diff[DATAWIDTH+1];
      nrem    = qbit ? diff[DATAWIDTH:0] : shifted[DATAWIDTH:0];
   end

endmodule

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
// Sequential unsigned restoring divider, one quotient bit per clock.
//   Clk          in  1          system clock, rising edge
//   Rst          in  1          synchronous active-high reset
//   start        in  1          request a division (accepted only in IDLE)
//   a            in  DATAWIDTH  dividend
//   b            in  DATAWIDTH  divisor
//   busy         out 1          division in progress (RUN or FIN)
//   done         out 1          one-cycle completion pulse
//   quot         out DATAWIDTH  quotient, held until next completion
//   rem          out DATAWIDTH  remainder, held until next completion
//   div_by_zero  out 1          last completed division had b = 0
// -----------------------------------------------------------------------------
module iter_divider
   import div_pkg::*;
#(
   parameter int DATAWIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 start,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [DATAWIDTH-1:0] quot,
   output logic [DATAWIDTH-1:0] rem,
   output logic                 div_by_zero
);

   localparam int            CW       = div_cnt_w(DATAWIDTH);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DATAWIDTH - 1);

   div_state_t           state;
   div_state_t           next_state;
   logic                 accept;
   logic                 iterate;
   logic                 finish;

   logic [DATAWIDTH:0]   prem;
   logic [DATAWIDTH-1:0] qreg;
   logic [DATAWIDTH-1:0] divisor;
   logic [CW-1:0]        cnt;

   logic [DATAWIDTH:0]   step_rem;
   logic                 step_q;

   // ---- controller: state register ----
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
      end
   end

   // ---- controller: next state and strobes ----
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      iterate    = 1'b0;
      finish     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept = 1'b1;
               // A zero divisor skips the iterations entirely.
               next_state = (b == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            iterate = 1'b1;
            if (cnt == '0) next_state = FIN;
         end
         FIN: begin
            finish     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // ---- datapath: operand capture and iteration ----
   // qreg starts as the dividend and is shifted out MSB-first into the
   // remainder while quotient bits enter at the LSB.
   always_ff @(posedge Clk) begin
      if (accept) begin
         qreg    <= a;
         divisor <= b;
         prem    <= '0;
         cnt     <= CNT_LOAD;
      end else if (iterate) begin
         qreg <= {qreg[DATAWIDTH-2:0], step_q};
         prem <= step_rem;
         cnt  <= cnt - CW'(1);
      end
   end

   div_step #(
      .DATAWIDTH(DATAWIDTH)
   ) u_step (
      .prem   (prem),
      .in_bit (qreg[DATAWIDTH-1]),
      .divisor(divisor),
      .nrem   (step_rem),
      .qbit   (step_q)
   );

   // ---- result registers ----
   // On divide-by-zero qreg still holds the untouched dividend, which is
   // exactly the remainder to report.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         done        <= 1'b0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            if (divisor == '0) begin
               quot        <= '1;
               rem         <= qreg;
               div_by_zero <= 1'b1;
            end else begin
               quot        <= qreg;
               rem         <= prem[DATAWIDTH-1:0];
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// -----------------------------------------------------------------------------
// tb_iter_divider
// Self-checking bench for iter_divider (DATAWIDTH = 8). Stimulus tasks push
// expected results into a scoreboard; a monitor pops and compares on done.
// -----------------------------------------------------------------------------
module tb_iter_divider;

   localparam int DW = 8;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] a = '0;
   logic [DW-1:0] b = '0;
   logic          busy;
   logic          done;
   logic [DW-1:0] quot;
   logic [DW-1:0] rem;
   logic          div_by_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      logic          dz;
      int            cyc;
   } exp_t;

   exp_t sb[$];

   iter_divider #(
      .DATAWIDTH(DW)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .quot       (quot),
      .rem        (rem),
      .div_by_zero(div_by_zero)
   );

   always #5 Clk = ~Clk;

   // cyc = index of the most recent rising edge
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                  input int done_cyc);
      exp_t e;
      e.a   = x;
      e.b   = y;
      e.cyc = done_cyc;
      if (y == '0) begin
         e.q  = '1;
         e.r  = x;
         e.dz = 1'b1;
      end else begin
         e.q  = x / y;
         e.r  = x % y;
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard monitor
   always @(negedge Clk) begin : mon
      exp_t e;
      if (!Rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done cyc=%0d quot=%0d rem=%0d required=no done", cyc, quot, rem);
         end else begin
            e = sb.pop_front();
            checks++;
            if (cyc !== e.cyc) begin
               errors++;
               $display("FAIL latency %0d/%0d done_edge=%0d required=%0d", e.a, e.b, cyc, e.cyc);
            end
            checks++;
            if (quot !== e.q) begin
               errors++;
               $display("FAIL quot %0d/%0d got=%0d required=%0d", e.a, e.b, quot, e.q);
            end
            checks++;
            if (rem !== e.r) begin
               errors++;
               $display("FAIL rem %0d/%0d got=%0d required=%0d", e.a, e.b, rem, e.r);
            end
            checks++;
            if (div_by_zero !== e.dz) begin
               errors++;
               $display("FAIL div_by_zero %0d/%0d got=%0b required=%0b", e.a, e.b, div_by_zero, e.dz);
            end
            if (e.b != '0) begin
               checks++;
               if ((int'(quot) * int'(e.b) + int'(rem) != int'(e.a)) || (rem >= e.b)) begin
                  errors++;
                  $display("FAIL identity %0d/%0d got q=%0d r=%0d required q*b+r=a and r<b",
                           e.a, e.b, quot, rem);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d required=completion", cyc);
      $fatal(1, "watchdog expired");
   end

   // Leaves the caller at a falling edge with busy = 0.
   task automatic wait_idle();
      int n = 0;
      @(negedge Clk);
      while (busy && n < 40) begin
         @(negedge Clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout busy=%0b required=0", busy);
      end
   endtask

   task automatic issue(input logic [DW-1:0] x, input logic [DW-1:0] y);
      wait_idle();
      a     = x;
      b     = y;
      start = 1'b1;
      sb.push_back(model(x, y, cyc + 1 + ((y == '0) ? 1 : DW + 1)));
      @(posedge Clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge Clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
         sb.delete();
      end
      @(negedge Clk);
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b required=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b required=0", done); end
      checks++;
      if (quot !== '0) begin errors++; $display("FAIL reset_quot got=%0d required=0", quot); end
      checks++;
      if (rem !== '0) begin errors++; $display("FAIL reset_rem got=%0d required=0", rem); end
      checks++;
      if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%0b required=0", div_by_zero); end
      Rst = 1'b0;
   endtask

   task automatic test_basic();
      issue(8'd100, 8'd7);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got=%0b required=1", busy); end
      wait_drain();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got=%0b required=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got=%0b required=0", done); end
      issue(8'd5, 8'd9);
      issue(8'd255, 8'd1);
      wait_drain();
   endtask

   task automatic test_div_zero();
      issue(8'd42, 8'd0);
      wait_drain();
      repeat (3) @(negedge Clk);
      checks++;
      if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got=%0b required=1", div_by_zero); end
      checks++;
      if (quot !== 8'd255) begin errors++; $display("FAIL quot_hold got=%0d required=255", quot); end
      issue(8'd100, 8'd7);
      wait_drain();
   endtask

   task automatic test_busy_ignore();
      int k;
      wait_idle();
      a     = 8'd100;
      b     = 8'd7;
      start = 1'b1;
      k     = cyc + 1;
      sb.push_back(model(8'd100, 8'd7, k + DW + 1));
      @(posedge Clk);
      #1;
      for (int i = 0; i < DW; i++) begin
         @(negedge Clk);
         a     = DW'($urandom_range(0, 255));
         b     = DW'($urandom_range(0, 255));
         start = 1'($urandom_range(0, 1));
      end
      // FIN cycle: present the next operands and hold start through done
      @(negedge Clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_fin got=%0b required=1", busy); end
      a     = 8'd200;
      b     = 8'd3;
      start = 1'b1;
      sb.push_back(model(8'd200, 8'd3, k + DW + 2 + DW + 1));
      repeat (2) @(negedge Clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL held_start_accept busy=%0b required=1", busy); end
      start = 1'b0;
      wait_drain();
   endtask

   task automatic test_reset_abort();
      int seen;
      wait_idle();
      a     = 8'd100;
      b     = 8'd7;
      start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      repeat (4) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b required=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%0b required=0", done); end
      checks++;
      if (quot !== '0) begin errors++; $display("FAIL abort_quot got=%0d required=0", quot); end
      checks++;
      if (rem !== '0) begin errors++; $display("FAIL abort_rem got=%0d required=0", rem); end
      Rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < DW + 4; i++) begin
         @(negedge Clk);
         if (done) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL abort_no_done pulses=%0d required=0", seen); end
   endtask

   task automatic test_random();
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      issue(8'd0, 8'd1);
      issue(8'd255, 8'd255);
      issue(8'd1, 8'd255);
      issue(8'd0, 8'd0);
      issue(8'd255, 8'd0);
      for (int i = 0; i < 1000; i++) begin
         x = DW'($urandom_range(0, 255));
         y = ($urandom_range(0, 15) == 0) ? '0 : DW'($urandom_range(0, 255));
         issue(x, y);
      end
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_busy_ignore();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
